// File: rtl/cam_capture_rgb332.sv
// Camera capture front end: OV7670-style VSYNC/HREF byte stream to RGB332 frame-buffer writes.
// Define CAM_TEST_PATTERN_EN to replace W_DATA with eight vertical colour bars.
module cam_capture_rgb332 #(
   parameter int unsigned WIDTH    = 176,
   parameter int unsigned HEIGHT   = 144,
   parameter int unsigned ADDR_W   = 15,
   parameter int unsigned PIX_FMT  = 0,
   parameter int unsigned DECIMATE = 1
) (
   input  logic              CLOCK,
   input  logic              RESET,
   input  logic              CAM_VSYNC,
   input  logic              CAM_HREF,
   input  logic [7:0]        CAM_DATA,
   output logic [ADDR_W-1:0] W_ADDR,
   output logic [7:0]        W_DATA,
   output logic              W_EN,
   output logic              FRAME_DONE,
   output logic [9:0]        LINE_COUNT,
   output logic              LINE_OVF,
   output logic              FRAME_OVF
);

   localparam int unsigned XW = $clog2(WIDTH + 1);
   localparam int unsigned YW = $clog2(HEIGHT + 1);
   localparam logic [XW-1:0]     X_LIM    = XW'(WIDTH);
   localparam logic [YW-1:0]     Y_LIM    = YW'(HEIGHT);
   localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(WIDTH);
   localparam bit                DEC2     = (DECIMATE == 2);

   typedef enum logic [1:0] {
      ST_SYNC,
      ST_VBLANK,
      ST_FRAME
   } state_t;

   state_t            state_q, state_d;
   logic              vsync_q, href_q;
   logic              line_act_q, line_act_d;
   logic              phase_q, phase_d;
   logic [7:0]        hi_q, hi_d;
   logic              pix_odd_q, pix_odd_d;
   logic [XW-1:0]     x_q, x_d;
   logic [YW-1:0]     y_q, y_d;
   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [9:0]        line_count_q, line_count_d;
   logic              line_ovf_q, line_ovf_d;
   logic              frame_ovf_q, frame_ovf_d;
   logic              w_en_q, w_en_d;
   logic [7:0]        w_data_q, w_data_d;
   logic [ADDR_W-1:0] w_addr_q, w_addr_d;
   logic              frame_done_q, frame_done_d;

   logic              vs_rise, href_rise;
   logic              line_kept, pix_kept;
   logic              clear_frame;
   logic [7:0]        pix_rgb;
   logic              unused_bits;

`ifdef CAM_TEST_PATTERN_EN
   localparam int unsigned  BAR_W    = (WIDTH >= 8) ? WIDTH / 8 : 1;
   localparam int unsigned  BW       = (BAR_W > 1) ? $clog2(BAR_W) : 1;
   localparam logic [BW-1:0] BAR_LAST = BW'(BAR_W - 1);

   logic [2:0]    band_q, band_d;
   logic [BW-1:0] band_cnt_q, band_cnt_d;
`endif

   assign vs_rise   = CAM_VSYNC & ~vsync_q;
   assign href_rise = CAM_HREF & ~href_q;
   // Decimation keys off the pre-decimation line count and a per-line input pixel parity.
   assign line_kept = !DEC2 || !line_count_q[0];
   assign pix_kept  = line_kept && (!DEC2 || !pix_odd_q);

   assign unused_bits = ^{hi_q, CAM_DATA};

`ifdef CAM_TEST_PATTERN_EN
   always_comb begin
      case (band_q)
         3'd0:    pix_rgb = 8'hFF;
         3'd1:    pix_rgb = 8'hFC;
         3'd2:    pix_rgb = 8'h1F;
         3'd3:    pix_rgb = 8'h1C;
         3'd4:    pix_rgb = 8'hE3;
         3'd5:    pix_rgb = 8'hE0;
         3'd6:    pix_rgb = 8'h03;
         default: pix_rgb = 8'h00;
      endcase
   end
`else
   // hi_q holds the phase-0 byte; the phase-1 byte is still on CAM_DATA.
   always_comb begin
      case (PIX_FMT)
         32'd1:   pix_rgb = {hi_q[3:1], CAM_DATA[7:5], CAM_DATA[3:2]};
         32'd2:   pix_rgb = {hi_q[7:5], hi_q[7:5], hi_q[7:6]};
         default: pix_rgb = {hi_q[7:5], hi_q[2:0], CAM_DATA[4:3]};
      endcase
   end
`endif

   always_comb begin
      state_d      = state_q;
      line_act_d   = line_act_q;
      phase_d      = phase_q;
      hi_d         = hi_q;
      pix_odd_d    = pix_odd_q;
      x_d          = x_q;
      y_d          = y_q;
      row_base_d   = row_base_q;
      line_count_d = line_count_q;
      line_ovf_d   = line_ovf_q;
      frame_ovf_d  = frame_ovf_q;
      w_en_d       = 1'b0;
      w_data_d     = w_data_q;
      w_addr_d     = w_addr_q;
      frame_done_d = 1'b0;
      clear_frame  = 1'b0;
`ifdef CAM_TEST_PATTERN_EN
      band_d       = band_q;
      band_cnt_d   = band_cnt_q;
`endif

      unique case (state_q)
         ST_SYNC: begin
            if (vs_rise) begin
               state_d     = ST_VBLANK;
               clear_frame = 1'b1;
            end
         end
         ST_VBLANK: begin
            if (!CAM_VSYNC) state_d = ST_FRAME;
         end
         ST_FRAME: begin
            if (vs_rise) begin
               state_d      = ST_VBLANK;
               clear_frame  = 1'b1;
               frame_done_d = (line_count_q != '0);
            end else if (CAM_HREF && (line_act_q || href_rise)) begin
               line_act_d = 1'b1;
               if (!phase_q) begin
                  hi_d    = CAM_DATA;
                  phase_d = 1'b1;
               end else begin
                  phase_d   = 1'b0;
                  pix_odd_d = ~pix_odd_q;
                  if (pix_kept) begin
                     if (x_q < X_LIM) begin
                        x_d = x_q + 1'b1;
                        if (y_q < Y_LIM) begin
                           w_en_d   = 1'b1;
                           w_addr_d = row_base_q + ADDR_W'(x_q);
                           w_data_d = pix_rgb;
                        end
`ifdef CAM_TEST_PATTERN_EN
                        if (band_cnt_q == BAR_LAST) begin
                           band_cnt_d = '0;
                           if (band_q != 3'd7) band_d = band_q + 1'b1;
                        end else begin
                           band_cnt_d = band_cnt_q + 1'b1;
                        end
`endif
                     end else begin
                        line_ovf_d = 1'b1;
                     end
                     if (y_q >= Y_LIM) frame_ovf_d = 1'b1;
                  end
               end
            end else if (line_act_q) begin
               // HREF fall: any dangling phase-0 byte is dropped with the phase reset.
               line_act_d = 1'b0;
               phase_d    = 1'b0;
               pix_odd_d  = 1'b0;
               x_d        = '0;
`ifdef CAM_TEST_PATTERN_EN
               band_d     = '0;
               band_cnt_d = '0;
`endif
               if (line_count_q != '1) line_count_d = line_count_q + 1'b1;
               if (line_kept && (y_q < Y_LIM)) begin
                  y_d        = y_q + 1'b1;
                  row_base_d = row_base_q + ROW_STEP;
               end
            end
         end
         default: state_d = ST_SYNC;
      endcase

      if (clear_frame) begin
         line_act_d   = 1'b0;
         phase_d      = 1'b0;
         pix_odd_d    = 1'b0;
         x_d          = '0;
         y_d          = '0;
         row_base_d   = '0;
         line_count_d = '0;
         line_ovf_d   = 1'b0;
         frame_ovf_d  = 1'b0;
`ifdef CAM_TEST_PATTERN_EN
         band_d       = '0;
         band_cnt_d   = '0;
`endif
      end
   end

   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q      <= ST_SYNC;
         vsync_q      <= 1'b0;
         href_q       <= 1'b0;
         line_act_q   <= 1'b0;
         phase_q      <= 1'b0;
         hi_q         <= '0;
         pix_odd_q    <= 1'b0;
         x_q          <= '0;
         y_q          <= '0;
         row_base_q   <= '0;
         line_count_q <= '0;
         line_ovf_q   <= 1'b0;
         frame_ovf_q  <= 1'b0;
         w_en_q       <= 1'b0;
         w_data_q     <= '0;
         w_addr_q     <= '0;
         frame_done_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         vsync_q      <= CAM_VSYNC;
         href_q       <= CAM_HREF;
         line_act_q   <= line_act_d;
         phase_q      <= phase_d;
         hi_q         <= hi_d;
         pix_odd_q    <= pix_odd_d;
         x_q          <= x_d;
         y_q          <= y_d;
         row_base_q   <= row_base_d;
         line_count_q <= line_count_d;
         line_ovf_q   <= line_ovf_d;
         frame_ovf_q  <= frame_ovf_d;
         w_en_q       <= w_en_d;
         w_data_q     <= w_data_d;
         w_addr_q     <= w_addr_d;
         frame_done_q <= frame_done_d;
      end
   end

`ifdef CAM_TEST_PATTERN_EN
   always_ff @(posedge CLOCK or posedge RESET) begin
      if (RESET) begin
         band_q     <= '0;
         band_cnt_q <= '0;
      end else begin
         band_q     <= band_d;
         band_cnt_q <= band_cnt_d;
      end
   end
`endif

   assign W_ADDR     = w_addr_q;
   assign W_DATA     = w_data_q;
   assign W_EN       = w_en_q;
   assign FRAME_DONE = frame_done_q;
   assign LINE_COUNT = line_count_q;
   assign LINE_OVF   = line_ovf_q;
   assign FRAME_OVF  = frame_ovf_q;

endmodule

// File: tb/tb_cam_capture_rgb332.sv
// Randomized bench: one stimulus stream drives three differently configured captures,
// each checked against a frame/line/pixel reference model.
module tb_cam_capture_rgb332;

   logic       clk = 1'b0;
   logic       rst;
   logic       vs;
   logic       href;
   logic [7:0] data;

   always #5 clk = ~clk;

   // config 0: defaults; 1: small YUV; 2: RGB444 with 2:1 decimation
   localparam int CW[3] = '{176, 6, 4};
   localparam int CH[3] = '{144, 3, 2};
   localparam int CF[3] = '{0, 2, 1};
   localparam int CD[3] = '{1, 1, 2};

   logic [14:0] w_addr0;
   logic [4:0]  w_addr1;
   logic [2:0]  w_addr2;
   logic [7:0]  w_data0, w_data1, w_data2;
   logic        w_en0, w_en1, w_en2;
   logic        done0, done1, done2;
   logic [9:0]  lc0, lc1, lc2;
   logic        lovf0, lovf1, lovf2;
   logic        fovf0, fovf1, fovf2;

   cam_capture_rgb332 #(.WIDTH(176), .HEIGHT(144), .ADDR_W(15), .PIX_FMT(0), .DECIMATE(1)) u_dut0 (
      .CLOCK(clk), .RESET(rst), .CAM_VSYNC(vs), .CAM_HREF(href), .CAM_DATA(data),
      .W_ADDR(w_addr0), .W_DATA(w_data0), .W_EN(w_en0), .FRAME_DONE(done0),
      .LINE_COUNT(lc0), .LINE_OVF(lovf0), .FRAME_OVF(fovf0));

   cam_capture_rgb332 #(.WIDTH(6), .HEIGHT(3), .ADDR_W(5), .PIX_FMT(2), .DECIMATE(1)) u_dut1 (
      .CLOCK(clk), .RESET(rst), .CAM_VSYNC(vs), .CAM_HREF(href), .CAM_DATA(data),
      .W_ADDR(w_addr1), .W_DATA(w_data1), .W_EN(w_en1), .FRAME_DONE(done1),
      .LINE_COUNT(lc1), .LINE_OVF(lovf1), .FRAME_OVF(fovf1));

   cam_capture_rgb332 #(.WIDTH(4), .HEIGHT(2), .ADDR_W(3), .PIX_FMT(1), .DECIMATE(2)) u_dut2 (
      .CLOCK(clk), .RESET(rst), .CAM_VSYNC(vs), .CAM_HREF(href), .CAM_DATA(data),
      .W_ADDR(w_addr2), .W_DATA(w_data2), .W_EN(w_en2), .FRAME_DONE(done2),
      .LINE_COUNT(lc2), .LINE_OVF(lovf2), .FRAME_OVF(fovf2));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // reference model state: expected writes packed as addr*256 + data
   int q0[$], q1[$], q2[$];
   int m_lines;
   int m_kept[3];
   bit m_lovf[3], m_fovf[3];
   bit in_frame;
   int px_n;
   int px_hi[256], px_lo[256];

   function automatic int conv(input int fmt, input int hi, input int lo);
      case (fmt)
         1:       return ((hi % 16) / 2) * 32 + (lo / 32) * 4 + (lo % 16) / 4;
         2:       return (hi / 32) * 32 + (hi / 32) * 4 + hi / 64;
         default: return (hi / 32) * 32 + (hi % 8) * 4 + (lo / 8) % 4;
      endcase
   endfunction

   function automatic int pixel(input int k, input int x, input int p);
`ifdef CAM_TEST_PATTERN_EN
      int bars[8] = '{'hFF, 'hFC, 'h1F, 'h1C, 'hE3, 'hE0, 'h03, 'h00};
      int bw = (CW[k] >= 8) ? CW[k] / 8 : 1;
      int b  = x / bw;
      if (b > 7) b = 7;
      return bars[b];
`else
      return conv(CF[k], px_hi[p], px_lo[p]);
`endif
   endfunction

   task automatic push(input int k, input int v);
      case (k)
         0:       q0.push_back(v);
         1:       q1.push_back(v);
         default: q2.push_back(v);
      endcase
   endtask

   task automatic model_reset();
      m_lines = 0;
      for (int k = 0; k < 3; k++) begin
         m_kept[k] = 0;
         m_lovf[k] = 0;
         m_fovf[k] = 0;
      end
   endtask

   task automatic model_line();
      for (int k = 0; k < 3; k++) begin
         bit kl = (CD[k] == 1) || (m_lines % 2 == 0);
         int x  = 0;
         if (kl) begin
            for (int p = 0; p < px_n; p++) begin
               if (CD[k] == 1 || p % 2 == 0) begin
                  if (x < CW[k] && m_kept[k] < CH[k])
                     push(k, (m_kept[k] * CW[k] + x) * 256 + pixel(k, x, p));
                  if (x >= CW[k]) m_lovf[k] = 1;
                  if (m_kept[k] >= CH[k]) m_fovf[k] = 1;
                  x++;
               end
            end
            m_kept[k]++;
         end
      end
      m_lines++;
   endtask

   task automatic take(input int k, input logic [31:0] a, input logic [31:0] d);
      int e = 0;
      bit have = 0;
      case (k)
         0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1; end
         1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1; end
         default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1; end
      endcase
      if (!have) chk($sformatf("unexpected_wen%0d", k), 1, 0);
      else begin
         chk($sformatf("w_addr%0d", k), a, e / 256);
         chk($sformatf("w_data%0d", k), d, e % 256);
      end
   endtask

   always @(negedge clk) if (w_en0 === 1'b1) take(0, w_addr0, w_data0);
   always @(negedge clk) if (w_en1 === 1'b1) take(1, w_addr1, w_data1);
   always @(negedge clk) if (w_en2 === 1'b1) take(2, w_addr2, w_data2);

   task automatic send(input int b);
      @(posedge clk);
      #1 href = 1'b1;
      data = b[7:0];
   endtask

   // mode 0 random bytes, 1 hi=F8/lo=00, 2 Y alternating A0/60
   task automatic drive_line(input int n, input bit odd_in, input int mode, input bit use_model);
      bit odd = odd_in || (n == 0);
      px_n = n;
      for (int p = 0; p < n; p++) begin
         case (mode)
            1:       begin px_hi[p] = 'hF8; px_lo[p] = 'h00; end
            2:       begin px_hi[p] = (p % 2 == 0) ? 'hA0 : 'h60; px_lo[p] = $urandom_range(0, 255); end
            default: begin px_hi[p] = $urandom_range(0, 255); px_lo[p] = $urandom_range(0, 255); end
         endcase
      end
      if (use_model) model_line();
      for (int p = 0; p < n; p++) begin
         send(px_hi[p]);
         send(px_lo[p]);
      end
      if (odd) send($urandom_range(0, 255));
      @(posedge clk);
      #1 href = 1'b0;
      data = $urandom_range(0, 255);
      repeat ($urandom_range(2, 5)) @(posedge clk);
   endtask

   task automatic vsync_pulse();
      bit exp_done = in_frame && (m_lines > 0);
      @(posedge clk);
      #1 vs = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("frame_done0", done0, exp_done);
      chk("frame_done1", done1, exp_done);
      chk("frame_done2", done2, exp_done);
      chk("lc_cleared0", lc0, 0);
      chk("lovf_cleared0", lovf0, 0);
      chk("fovf_cleared1", fovf1, 0);
      chk("lovf_cleared2", lovf2, 0);
      @(negedge clk);
      chk("frame_done_pulse0", done0, 0);
      repeat (2) @(posedge clk);
      #1 vs = 1'b0;
      repeat (3) @(posedge clk);
      model_reset();
      in_frame = 1;
   endtask

   task automatic end_frame_check();
      int lc_exp = (m_lines > 1023) ? 1023 : m_lines;
      @(negedge clk);
      chk("line_count0", lc0, lc_exp);
      chk("line_count1", lc1, lc_exp);
      chk("line_count2", lc2, lc_exp);
      chk("line_ovf0", lovf0, m_lovf[0]);
      chk("line_ovf1", lovf1, m_lovf[1]);
      chk("line_ovf2", lovf2, m_lovf[2]);
      chk("frame_ovf0", fovf0, m_fovf[0]);
      chk("frame_ovf1", fovf1, m_fovf[1]);
      chk("frame_ovf2", fovf2, m_fovf[2]);
      chk("pending0", q0.size(), 0);
      chk("pending1", q1.size(), 0);
      chk("pending2", q2.size(), 0);
   endtask

   task automatic reset_values();
      chk("rst_w_addr0", w_addr0, 0);
      chk("rst_w_data0", w_data0, 0);
      chk("rst_w_en0", w_en0, 0);
      chk("rst_done0", done0, 0);
      chk("rst_lc0", lc0, 0);
      chk("rst_lovf0", lovf0, 0);
      chk("rst_fovf0", fovf0, 0);
      chk("rst_w_en1", w_en1, 0);
      chk("rst_w_data1", w_data1, 0);
      chk("rst_w_en2", w_en2, 0);
      chk("rst_w_addr2", w_addr2, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int nl, r, n;
      rst = 1'b1; vs = 1'b0; href = 1'b0; data = '0;
      in_frame = 0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 reset_values();
      @(negedge clk);
      #1 rst = 1'b0;

      // no VSYNC seen yet: line must be ignored
      drive_line(10, 0, 0, 0);

      vsync_pulse();
      drive_line(176, 0, 1, 1);
      drive_line(176, 0, 1, 1);
      end_frame_check();

      vsync_pulse();
      drive_line(4, 0, 2, 1);
      drive_line(8, 0, 0, 1);
      drive_line(180, 0, 0, 1);
      drive_line(12, 1, 0, 1);
      drive_line(8, 0, 0, 1);
      end_frame_check();

      for (int f = 0; f < 5; f++) begin
         vsync_pulse();
         nl = $urandom_range(1, 7);
         for (int l = 0; l < nl; l++) begin
            r = $urandom_range(0, 9);
            n = (r < 2) ? 176 : (r < 4) ? 180 : $urandom_range(0, 14);
            drive_line(n, 1'($urandom_range(0, 1)), 0, 1);
         end
         end_frame_check();
      end

      vsync_pulse();
      end_frame_check();

      // mid-line reset, released while HREF is still high
      vsync_pulse();
      drive_line(6, 0, 0, 1);
      px_n = 5;
      for (int p = 0; p < 5; p++) begin
         px_hi[p] = $urandom_range(0, 255);
         px_lo[p] = $urandom_range(0, 255);
      end
      model_line();
      for (int p = 0; p < 5; p++) begin
         send(px_hi[p]);
         send(px_lo[p]);
      end
      @(posedge clk);
      #1 data = $urandom_range(0, 255);
      @(negedge clk);
      #1 rst = 1'b1;
      q0.delete(); q1.delete(); q2.delete();
      in_frame = 0;
      model_reset();
      #1 reset_values();
      repeat (3) begin
         @(posedge clk);
         #1 data = $urandom_range(0, 255);
      end
      @(negedge clk);
      #1 rst = 1'b0;
      repeat (8) send($urandom_range(0, 255));
      @(posedge clk);
      #1 href = 1'b0;
      repeat (3) @(posedge clk);
      drive_line(7, 0, 0, 0);
      end_frame_check();

      vsync_pulse();
      drive_line(9, 0, 0, 1);
      drive_line(3, 1, 0, 1);
      drive_line(5, 0, 0, 1);
      end_frame_check();
      vsync_pulse();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
